// File: rtl/sib_sync_filt_nch.sv
// Multi-channel level synchroniser with per-channel stability filter and
// registered rise/fall event pulses, all in the single clk domain.
module sib_sync_filt_nch #(
  parameter int                  NUM_CH      = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILT_CNT    = 3,
  parameter logic [NUM_CH-1:0]   RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              any_change
);

  localparam int             CW      = (FILT_CNT < 2) ? 1 : $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CNT);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  // Only these flops see asynchronous data; keep them as dedicated sync cells.
  (* async_reg = "true" *) logic [NUM_CH-1:0] meta_q;
  logic [NUM_CH-1:0] stage_q [SYNC_STAGES-1];
  logic [NUM_CH-1:0] sv;

  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] out_d;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its sources, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) meta_q <= RESET_VAL;
    else     meta_q <= async_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES - 1; k++) stage_q[k] <= RESET_VAL;
    end else begin
      stage_q[0] <= meta_q;
      for (int k = 1; k < SYNC_STAGES - 1; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign sv = stage_q[SYNC_STAGES-2];

  // NOTE: every variable gets its hold value before the loop, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = sync_out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sv[i] == sync_out[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // Deviation has held FILT_CNT+1 cycles: accept it and flag the edge.
        out_d[i]  = sv[i];
        cnt_d[i]  = '0;
        rise_d[i] = sv[i];
        fall_d[i] = ~sv[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // NOTE: the counter array is small control state, not a RAM, so it is
  // cleared on reset like any other register to discard partial counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      sync_out   <= RESET_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sync_out   <= out_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      any_change <= |(rise_d | fall_d);
    end
  end

endmodule
